// File: rtl/rs_station_param.sv
// rs_station_param -- Tomasulo reservation station for one functional unit.
//
// Holds up to DEPTH dispatched instructions. Each cycle it snoops one CDB
// broadcast and captures operands by producer tag. It issues the oldest entry
// whose operands are both present. Entry i owns producer tag UNIT_BASE + i.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             synchronous clear of all entries (mispredict)
//   disp_*              dispatch request/handshake; disp_tag_o = tag allocated
//   cdb_*               common data bus snoop (valid, tag, data)
//   iss_*               issue request/handshake towards the execution unit
//   count_o             number of busy entries (0..DEPTH)
module rs_station_param #(
  parameter int               DEPTH     = 8,
  parameter int               WORD_W    = 32,
  parameter int               TAG_W     = 8,
  parameter int               OP_W      = 3,
  parameter logic [TAG_W-1:0] UNIT_BASE = 'h20
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         disp_valid_i,
  output logic                         disp_ready_o,
  input  logic [OP_W-1:0]              disp_op_i,
  input  logic                         disp_a_rdy_i,
  input  logic [TAG_W-1:0]             disp_a_tag_i,
  input  logic [WORD_W-1:0]            disp_a_val_i,
  input  logic                         disp_b_rdy_i,
  input  logic [TAG_W-1:0]             disp_b_tag_i,
  input  logic [WORD_W-1:0]            disp_b_val_i,
  output logic [TAG_W-1:0]             disp_tag_o,
  input  logic                         cdb_valid_i,
  input  logic [TAG_W-1:0]             cdb_tag_i,
  input  logic [WORD_W-1:0]            cdb_data_i,
  output logic                         iss_valid_o,
  input  logic                         iss_ready_i,
  output logic [OP_W-1:0]              iss_op_o,
  output logic [WORD_W-1:0]            iss_a_o,
  output logic [WORD_W-1:0]            iss_b_o,
  output logic [TAG_W-1:0]             iss_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  busy_q, busy_d, a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [TAG_W-1:0]  a_tag_q [DEPTH];
  logic [TAG_W-1:0]  a_tag_d [DEPTH];
  logic [TAG_W-1:0]  b_tag_q [DEPTH];
  logic [TAG_W-1:0]  b_tag_d [DEPTH];
  logic [WORD_W-1:0] a_val_q [DEPTH];
  logic [WORD_W-1:0] a_val_d [DEPTH];
  logic [WORD_W-1:0] b_val_q [DEPTH];
  logic [WORD_W-1:0] b_val_d [DEPTH];
  // age_q[i][j] = 1 means entry i is older than entry j. Only meaningful
  // between busy entries; stale bits for free entries are rewritten on alloc.
  logic [DEPTH-1:0]  age_q   [DEPTH];
  logic [DEPTH-1:0]  age_d   [DEPTH];

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     alloc_idx, sel_idx;
  logic              sel_ok, disp_fire, iss_fire, fwd_a, fwd_b;
  logic [DEPTH-1:0]  cand;

  // Occupancy and lowest-free allocation, both from pre-edge busy.
  always_comb begin
    cnt       = '0;
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      cnt = cnt + CW'(busy_q[i]);
      if (!busy_q[i]) alloc_idx = IW'(i);
    end
  end

  assign count_o      = cnt;
  assign disp_ready_o = (cnt != CW'(DEPTH));
  assign disp_tag_o   = UNIT_BASE + TAG_W'(alloc_idx);
  assign disp_fire    = disp_valid_i & disp_ready_o;

  // Oldest-ready select: a candidate wins if it is older than every other
  // candidate. The age matrix is a total order on busy entries, so at most
  // one wins.
  assign cand = busy_q & a_rdy_q & b_rdy_q;

  always_comb begin
    logic oldest;
    sel_idx = '0;
    sel_ok  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest = cand[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && cand[j] && !age_q[i][j]) oldest = 1'b0;
      if (oldest && !sel_ok) begin
        sel_idx = IW'(i);
        sel_ok  = 1'b1;
      end
    end
  end

  assign iss_valid_o = sel_ok;
  assign iss_op_o    = sel_ok ? op_q[sel_idx]    : '0;
  assign iss_a_o     = sel_ok ? a_val_q[sel_idx] : '0;
  assign iss_b_o     = sel_ok ? b_val_q[sel_idx] : '0;
  assign iss_tag_o   = sel_ok ? UNIT_BASE + TAG_W'(sel_idx) : '0;
  assign iss_fire    = sel_ok & iss_ready_i;

  // A result broadcast in the dispatch cycle would otherwise slip past the
  // new entry, since it is not yet busy and cannot snoop.
  assign fwd_a = cdb_valid_i && !disp_a_rdy_i && (cdb_tag_i == disp_a_tag_i);
  assign fwd_b = cdb_valid_i && !disp_b_rdy_i && (cdb_tag_i == disp_b_tag_i);

  always_comb begin
    busy_d  = busy_q;
    a_rdy_d = a_rdy_q;
    b_rdy_d = b_rdy_q;
    op_d    = op_q;
    a_tag_d = a_tag_q;
    b_tag_d = b_tag_q;
    a_val_d = a_val_q;
    b_val_d = b_val_q;
    age_d   = age_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && !a_rdy_q[i] && cdb_valid_i && cdb_tag_i == a_tag_q[i]) begin
        a_rdy_d[i] = 1'b1;
        a_val_d[i] = cdb_data_i;
      end
      if (busy_q[i] && !b_rdy_q[i] && cdb_valid_i && cdb_tag_i == b_tag_q[i]) begin
        b_rdy_d[i] = 1'b1;
        b_val_d[i] = cdb_data_i;
      end
    end

    if (iss_fire) busy_d[sel_idx] = 1'b0;

    // alloc_idx is never the issuing entry: it was free before the edge.
    if (disp_fire) begin
      busy_d[alloc_idx]  = 1'b1;
      op_d[alloc_idx]    = disp_op_i;
      a_tag_d[alloc_idx] = disp_a_tag_i;
      b_tag_d[alloc_idx] = disp_b_tag_i;
      a_rdy_d[alloc_idx] = disp_a_rdy_i | fwd_a;
      b_rdy_d[alloc_idx] = disp_b_rdy_i | fwd_b;
      a_val_d[alloc_idx] = fwd_a ? cdb_data_i : disp_a_val_i;
      b_val_d[alloc_idx] = fwd_b ? cdb_data_i : disp_b_val_i;
      for (int j = 0; j < DEPTH; j++) age_d[j][alloc_idx] = busy_q[j];
      age_d[alloc_idx] = '0;
    end

    if (flush_i) begin
      busy_d = '0;
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
    end
  end

  // Payload needs no reset: it is only observed through busy entries.
  always_ff @(posedge clk_i) begin
    a_rdy_q <= a_rdy_d;
    b_rdy_q <= b_rdy_d;
    op_q    <= op_d;
    a_tag_q <= a_tag_d;
    b_tag_q <= b_tag_d;
    a_val_q <= a_val_d;
    b_val_q <= b_val_d;
  end
endmodule

// File: tb/tb_rs_station_param.sv
module tb_rs_station_param;
  logic        clk = 1'b0;
  logic        rst, flush, dv, drdy, ardy, brdy, cv, iv, ir;
  logic [2:0]  op, iop;
  logic [7:0]  atag, btag, dtag, ctag, itag;
  logic [31:0] aval, bval, cdata, ia, ib;
  logic [3:0]  cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rs_station_param dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .disp_valid_i(dv), .disp_ready_o(drdy), .disp_op_i(op),
    .disp_a_rdy_i(ardy), .disp_a_tag_i(atag), .disp_a_val_i(aval),
    .disp_b_rdy_i(brdy), .disp_b_tag_i(btag), .disp_b_val_i(bval),
    .disp_tag_o(dtag),
    .cdb_valid_i(cv), .cdb_tag_i(ctag), .cdb_data_i(cdata),
    .iss_valid_o(iv), .iss_ready_i(ir), .iss_op_o(iop),
    .iss_a_o(ia), .iss_b_o(ib), .iss_tag_o(itag), .count_o(cnt)
  );

  typedef struct {
    logic        dv;  logic [2:0] op;
    logic        ardy; logic [7:0] atag; logic [31:0] aval;
    logic        brdy; logic [7:0] btag; logic [31:0] bval;
    logic        cv;  logic [7:0] ctag; logic [31:0] cdata;
    logic        ir;
    logic        e_drdy; logic [7:0] e_dtag; logic e_iv; logic [2:0] e_op;
    logic [31:0] e_a; logic [31:0] e_b; logic [7:0] e_tag; logic [3:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic d, logic [2:0] o, logic ar, logic [7:0] at, logic [31:0] av,
                              logic br, logic [7:0] bt, logic [31:0] bv,
                              logic c, logic [7:0] ct, logic [31:0] cd, logic r,
                              logic edr, logic [7:0] edt, logic eiv, logic [2:0] eop,
                              logic [31:0] ea, logic [31:0] eb, logic [7:0] etg, logic [3:0] ecn);
    vec_t v;
    v.dv = d; v.op = o; v.ardy = ar; v.atag = at; v.aval = av;
    v.brdy = br; v.btag = bt; v.bval = bv; v.cv = c; v.ctag = ct; v.cdata = cd; v.ir = r;
    v.e_drdy = edr; v.e_dtag = edt; v.e_iv = eiv; v.e_op = eop;
    v.e_a = ea; v.e_b = eb; v.e_tag = etg; v.e_cnt = ecn;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst = 0; flush = 0; dv = 0; op = 0; ardy = 0; atag = 0; aval = 0;
    brdy = 0; btag = 0; bval = 0; cv = 0; ctag = 0; cdata = 0; ir = 0;
  endtask

  task automatic disp(logic [2:0] o, logic ar, logic [7:0] at, logic [31:0] av,
                      logic br, logic [7:0] bt, logic [31:0] bv);
    dv = 1; op = o; ardy = ar; atag = at; aval = av; brdy = br; btag = bt; bval = bv;
  endtask

  task automatic chk_iss(string nm, logic [2:0] eop, logic [31:0] ea, logic [31:0] eb, logic [7:0] etg);
    chk({nm, ".iv"}, 32'(iv), 32'd1);
    chk({nm, ".op"}, 32'(iop), 32'(eop));
    chk({nm, ".a"}, ia, ea);
    chk({nm, ".b"}, ib, eb);
    chk({nm, ".tag"}, 32'(itag), 32'(etg));
  endtask

  initial begin
    // Table: T2 single ready dispatch, T3 CDB wakeup, T4 fill/full/drain.
    vq.push_back(mk(1,1,1,0,5, 1,0,7, 0,0,0,0,  1,8'h20,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,1,  1,8'h21,1,1,5,7,8'h20,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,  1,8'h20,0,0,0,0,0,0));
    vq.push_back(mk(1,2,0,8'h41,0, 1,0,3, 0,0,0,0, 1,8'h20,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 1,8'h41,32'h1234,0, 1,8'h21,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 1,8'h42,32'hFFFF,0, 1,8'h21,1,2,32'h1234,3,8'h20,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,1,  1,8'h21,1,2,32'h1234,3,8'h20,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,  1,8'h20,0,0,0,0,0,0));
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(1,3'(k),1,0,32'h100+k, 1,0,32'h200+k, 0,0,0,0,
                      1, 8'h20+8'(k), k>0, 0, k>0 ? 32'h100 : 0, k>0 ? 32'h200 : 0,
                      k>0 ? 8'h20 : 8'h00, 4'(k)));
    vq.push_back(mk(1,7,1,0,32'hDEAD, 1,0,32'hDEAD, 0,0,0,0, 0,0,1,0,32'h100,32'h200,8'h20,8));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,1,  0,0,1,0,32'h100,32'h200,8'h20,8));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,  1,8'h20,1,1,32'h101,32'h201,8'h21,7));
    for (int k = 1; k < 8; k++)
      vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,1, 1,8'h20,1,3'(k),32'h100+k,32'h200+k,
                      8'h20+8'(k), 4'(8-k)));
    vq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,  1,8'h20,0,0,0,0,0,0));

    // T1: reset
    idle(); rst = 1;
    tick(); tick();
    rst = 0; #1;
    chk("rst.count", 32'(cnt), 0);
    chk("rst.drdy", 32'(drdy), 1);
    chk("rst.iv", 32'(iv), 0);
    chk("rst.dtag", 32'(dtag), 32'h20);
    tick();

    foreach (vq[n]) begin
      idle();
      dv = vq[n].dv; op = vq[n].op; ardy = vq[n].ardy; atag = vq[n].atag; aval = vq[n].aval;
      brdy = vq[n].brdy; btag = vq[n].btag; bval = vq[n].bval;
      cv = vq[n].cv; ctag = vq[n].ctag; cdata = vq[n].cdata; ir = vq[n].ir;
      #1;
      chk($sformatf("v%0d.drdy", n), 32'(drdy), 32'(vq[n].e_drdy));
      if (vq[n].e_drdy) chk($sformatf("v%0d.dtag", n), 32'(dtag), 32'(vq[n].e_dtag));
      chk($sformatf("v%0d.iv", n), 32'(iv), 32'(vq[n].e_iv));
      chk($sformatf("v%0d.op", n), 32'(iop), 32'(vq[n].e_op));
      chk($sformatf("v%0d.a", n), ia, vq[n].e_a);
      chk($sformatf("v%0d.b", n), ib, vq[n].e_b);
      chk($sformatf("v%0d.tag", n), 32'(itag), 32'(vq[n].e_tag));
      chk($sformatf("v%0d.cnt", n), 32'(cnt), 32'(vq[n].e_cnt));
      tick();
    end

    // T5: entry 3 (older) and entry 1 (younger) woken by one CDB.
    idle(); disp(1, 0, 8'h66, 0, 1, 0, 32'h10); tick();            // e0 waits 0x66
    idle(); disp(2, 1, 0, 32'h11, 1, 0, 32'h12); #1;
    chk("t5.dtag1", 32'(dtag), 32'h21); tick();                     // e1 ready
    idle(); disp(3, 1, 0, 32'h13, 1, 0, 32'h14); tick();            // e2 ready
    idle(); disp(4, 0, 8'h55, 0, 1, 0, 32'h15); #1;
    chk_iss("t5.c4", 2, 32'h11, 32'h12, 8'h21); tick();             // e3 waits 0x55
    idle(); ir = 1; #1; chk("t5.c5.tag", 32'(itag), 32'h21); tick();
    idle(); ir = 1; #1; chk("t5.c6.tag", 32'(itag), 32'h22); tick();
    idle(); disp(5, 0, 8'h55, 0, 0, 8'h55, 0); #1;
    chk("t5.c7.dtag", 32'(dtag), 32'h21);
    chk("t5.c7.iv", 32'(iv), 0); tick();                            // e1 waits 0x55 on A and B
    idle(); cv = 1; ctag = 8'h55; cdata = 32'hABC; #1;
    chk("t5.c8.iv", 32'(iv), 0);
    chk("t5.c8.cnt", 32'(cnt), 3); tick();
    idle(); ir = 1; #1; chk_iss("t5.old", 4, 32'hABC, 32'h15, 8'h23); tick();
    idle(); ir = 1; #1; chk_iss("t5.young", 5, 32'hABC, 32'hABC, 8'h21); tick();
    idle(); cv = 1; ctag = 8'h66; cdata = 32'h99; #1;
    chk("t5.c11.iv", 32'(iv), 0);
    chk("t5.c11.cnt", 32'(cnt), 1); tick();
    idle(); ir = 1; #1; chk_iss("t5.e0", 1, 32'h99, 32'h10, 8'h20); tick();
    idle(); #1; chk("t5.end.cnt", 32'(cnt), 0);

    // T6: dispatch-cycle forwarding, then flush.
    idle(); disp(6, 0, 8'h77, 0, 1, 0, 32'h20);
    cv = 1; ctag = 8'h77; cdata = 32'hBEEF; #1;
    chk("t6.dtag", 32'(dtag), 32'h20); tick();
    idle(); #1;
    chk_iss("t6.fwd", 6, 32'hBEEF, 32'h20, 8'h20);
    chk("t6.cnt1", 32'(cnt), 1); tick();
    idle(); disp(7, 0, 8'h88, 0, 1, 0, 32'h1); tick();
    idle(); disp(2, 1, 0, 32'h3, 1, 0, 32'h4);
    flush = 1; ir = 1; cv = 1; ctag = 8'h88; cdata = 32'h5A5A; #1;
    chk("t6.preflush.cnt", 32'(cnt), 2); tick();
    idle(); #1;
    chk("t6.flush.cnt", 32'(cnt), 0);
    chk("t6.flush.iv", 32'(iv), 0);
    chk("t6.flush.drdy", 32'(drdy), 1);
    chk("t6.flush.dtag", 32'(dtag), 32'h20); tick();
    idle(); disp(7, 0, 8'h88, 0, 1, 0, 32'h1); tick();
    idle(); #1;
    chk("t6.post.cnt", 32'(cnt), 1);
    chk("t6.post.iv", 32'(iv), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
